// File: rtl/dpram_port_ctrl.sv
// rtl/dpram_port_ctrl.sv - two-port valid/ready initiator for the 32x32 dual-port SRAM
// Ports:
//   clk, rst               - system clock, synchronous active-high reset
//   reqN_valid/ready       - request handshake per port (N = 1, 2)
//   reqN_we/addr/wdata     - request operation, word address, write data
//   rspN_valid, rspN_rdata - one-cycle completion pulse, registered read data
//   AN, IN, ON             - SRAM address, write data, read data per port
//   CEBN                   - SRAM strobe, rising edge commits the access
//   WEBN, OEBN             - active-low write enable / output enable
//   CSB2                   - active-low port-2 chip select
//   conflict_cnt           - saturating count of cycles port 2 lost a collision
module dpram_port_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    input  logic              req2_valid,
    output logic              req2_ready,
    input  logic              req2_we,
    input  logic [ADDR_W-1:0] req2_addr,
    input  logic [DATA_W-1:0] req2_wdata,
    output logic              rsp2_valid,
    output logic [DATA_W-1:0] rsp2_rdata,
    output logic [ADDR_W-1:0] A1,
    output logic [DATA_W-1:0] I1,
    input  logic [DATA_W-1:0] O1,
    output logic              CEB1,
    output logic              WEB1,
    output logic              OEB1,
    output logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] I2,
    input  logic [DATA_W-1:0] O2,
    output logic              CEB2,
    output logic              WEB2,
    output logic              OEB2,
    output logic              CSB2,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t st1, st1_nxt, st2, st2_nxt;
    logic   we1_q, we2_q;
    logic   acc1, acc2, conflict, p1_inflight, p2_open;

    // Handshake and collision detection. A1 doubles as the port-1 in-flight
    // address because it is held unchanged from SETUP through DONE.
    always_comb begin
        p1_inflight = (st1 == S_SETUP) || (st1 == S_STROBE);
        p2_open     = (st2 == S_IDLE) || (st2 == S_DONE);
        req1_ready  = !rst && ((st1 == S_IDLE) || (st1 == S_DONE));
        acc1        = req1_valid && req1_ready;
        conflict    = 1'b0;
        if (req2_valid) begin
            if (p1_inflight && (req2_we || we1_q) && (req2_addr == A1))
                conflict = 1'b1;
            if (acc1 && (req2_we || req1_we) && (req2_addr == req1_addr))
                conflict = 1'b1;
        end
        req2_ready = !rst && p2_open && !conflict;
        acc2       = req2_valid && req2_ready;
    end

    always_comb begin
        st1_nxt = st1;
        case (st1)
            S_IDLE:   if (acc1) st1_nxt = S_SETUP;
            S_SETUP:  st1_nxt = S_STROBE;
            S_STROBE: st1_nxt = S_DONE;
            S_DONE:   st1_nxt = acc1 ? S_SETUP : S_IDLE;
        endcase
    end

    always_comb begin
        st2_nxt = st2;
        case (st2)
            S_IDLE:   if (acc2) st2_nxt = S_SETUP;
            S_SETUP:  st2_nxt = S_STROBE;
            S_STROBE: st2_nxt = S_DONE;
            S_DONE:   st2_nxt = acc2 ? S_SETUP : S_IDLE;
        endcase
    end

    // SRAM pins are driven from the next state so they are registered and
    // already valid in the cycle the FSM enters that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            st1        <= S_IDLE;
            we1_q      <= 1'b0;
            A1         <= '0;
            I1         <= '0;
            CEB1       <= 1'b0;
            WEB1       <= 1'b1;
            OEB1       <= 1'b1;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            st1        <= st1_nxt;
            rsp1_valid <= (st1 == S_DONE);
            if ((st1 == S_DONE) && !we1_q)
                rsp1_rdata <= O1;
            case (st1_nxt)
                S_SETUP: begin
                    A1    <= req1_addr;
                    I1    <= req1_wdata;
                    we1_q <= req1_we;
                    WEB1  <= ~req1_we;
                    OEB1  <= req1_we;
                    CEB1  <= 1'b0;
                end
                S_STROBE: CEB1 <= 1'b1;
                S_DONE: begin
                    CEB1 <= 1'b0;
                    WEB1 <= 1'b1;
                end
                S_IDLE: begin
                    CEB1 <= 1'b0;
                    WEB1 <= 1'b1;
                    OEB1 <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st2        <= S_IDLE;
            we2_q      <= 1'b0;
            A2         <= '0;
            I2         <= '0;
            CEB2       <= 1'b0;
            WEB2       <= 1'b1;
            OEB2       <= 1'b1;
            CSB2       <= 1'b1;
            rsp2_valid <= 1'b0;
            rsp2_rdata <= '0;
        end else begin
            st2        <= st2_nxt;
            rsp2_valid <= (st2 == S_DONE);
            CSB2       <= (st2_nxt == S_IDLE);
            if ((st2 == S_DONE) && !we2_q)
                rsp2_rdata <= O2;
            case (st2_nxt)
                S_SETUP: begin
                    A2    <= req2_addr;
                    I2    <= req2_wdata;
                    we2_q <= req2_we;
                    WEB2  <= ~req2_we;
                    OEB2  <= req2_we;
                    CEB2  <= 1'b0;
                end
                S_STROBE: CEB2 <= 1'b1;
                S_DONE: begin
                    CEB2 <= 1'b0;
                    WEB2 <= 1'b1;
                end
                S_IDLE: begin
                    CEB2 <= 1'b0;
                    WEB2 <= 1'b1;
                    OEB2 <= 1'b1;
                end
            endcase
        end
    end

    // Counts only cycles where port 2 could otherwise have been accepted.
    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= '0;
        else if (req2_valid && p2_open && conflict && (conflict_cnt != {CNT_W{1'b1}}))
            conflict_cnt <= conflict_cnt + 1'b1;
    end

endmodule

// File: tb/tb_dpram_port_ctrl.sv
// tb/tb_dpram_port_ctrl.sv - scoreboard bench for dpram_port_ctrl with a behavioural SRAM
module tb_dpram_port_ctrl;

    logic        clk, rst;
    logic        req1_valid, req1_ready, req1_we, rsp1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_wdata, rsp1_rdata;
    logic        req2_valid, req2_ready, req2_we, rsp2_valid;
    logic [4:0]  req2_addr;
    logic [31:0] req2_wdata, rsp2_rdata;
    logic [4:0]  A1, A2;
    logic [31:0] I1, I2, O1, O2;
    logic        CEB1, WEB1, OEB1, CEB2, WEB2, OEB2, CSB2;
    logic [15:0] conflict_cnt;

    dpram_port_ctrl dut (
        .clk(clk), .rst(rst),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .req2_valid(req2_valid), .req2_ready(req2_ready), .req2_we(req2_we),
        .req2_addr(req2_addr), .req2_wdata(req2_wdata),
        .rsp2_valid(rsp2_valid), .rsp2_rdata(rsp2_rdata),
        .A1(A1), .I1(I1), .O1(O1), .CEB1(CEB1), .WEB1(WEB1), .OEB1(OEB1),
        .A2(A2), .I2(I2), .O2(O2), .CEB2(CEB2), .WEB2(WEB2), .OEB2(OEB2),
        .CSB2(CSB2), .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural dual-port SRAM: access commits on the rising strobe edge.
    logic [31:0] sram [32];
    logic [31:0] o1_lat = 0, o2_lat = 0;
    int ceb1_rises = 0, ceb2_rises = 0, ceb1_last = 0, ceb2_last = 0;
    assign O1 = o1_lat;
    assign O2 = o2_lat;
    always @(posedge CEB1) begin
        ceb1_rises++; ceb1_last = cyc;
        if (!WEB1) sram[A1] = I1; else o1_lat = sram[A1];
    end
    always @(posedge CEB2) begin
        ceb2_rises++; ceb2_last = cyc;
        if (!WEB2) sram[A2] = I2; else o2_lat = sram[A2];
    end

    // Reference model: memory updated in acceptance order; each accepted
    // access yields one response 4 negedges later carrying the port's
    // current read-data register (writes leave it unchanged).
    typedef struct packed { logic [31:0] data; logic [31:0] cyc; } exp_t;
    exp_t sb1[$], sb2[$];
    logic [31:0] mem_m [32];
    logic [31:0] last1 = 0, last2 = 0;

    int web_low = 0, csb_low = 0, rsp1_n = 0;
    bit web_en = 0, csb_en = 0, stream_en = 0;
    int stream_n = 0, stream_last = 0, stream_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (web_en && !WEB1) web_low++;
        if (csb_en && !CSB2) csb_low++;
        if (rsp1_valid) begin
            rsp1_n++;
            if (stream_en) begin
                if (stream_n > 0 && (cyc - stream_last) != 3) stream_bad++;
                stream_last = cyc;
                stream_n++;
            end
            if (sb1.size() == 0) check("rsp1_unexpected", 1, 0);
            else begin
                e = sb1.pop_front();
                check("rsp1_rdata", rsp1_rdata, e.data);
                check("rsp1_cycle", cyc, e.cyc);
            end
        end
        if (rsp2_valid) begin
            if (sb2.size() == 0) check("rsp2_unexpected", 1, 0);
            else begin
                e = sb2.pop_front();
                check("rsp2_rdata", rsp2_rdata, e.data);
                check("rsp2_cycle", cyc, e.cyc);
            end
        end
        if (rst) begin
            sb1.delete(); sb2.delete();
            last1 = 0; last2 = 0;
        end else begin
            if (req1_valid && req1_ready) begin
                if (req1_we) mem_m[req1_addr] = req1_wdata;
                else last1 = mem_m[req1_addr];
                sb1.push_back('{last1, cyc + 4});
            end
            if (req2_valid && req2_ready) begin
                if (req2_we) mem_m[req2_addr] = req2_wdata;
                else last2 = mem_m[req2_addr];
                sb2.push_back('{last2, cyc + 4});
            end
        end
    end

    task automatic p1_req(input logic we, input logic [4:0] addr, input logic [31:0] data, output int waits);
        req1_valid = 1; req1_we = we; req1_addr = addr; req1_wdata = data;
        waits = 0;
        forever begin
            @(negedge clk);
            if (req1_ready) break;
            waits++;
            if (waits > 300) begin
                checks++; errors++;
                $display("FAIL p1_accept_timeout: waited %0d cycles, limit 300", waits);
                break;
            end
        end
        @(posedge clk); #1;
        req1_valid = 0;
    endtask

    task automatic p2_req(input logic we, input logic [4:0] addr, input logic [31:0] data, output int waits);
        req2_valid = 1; req2_we = we; req2_addr = addr; req2_wdata = data;
        waits = 0;
        forever begin
            @(negedge clk);
            if (req2_ready) break;
            waits++;
            if (waits > 300) begin
                checks++; errors++;
                $display("FAIL p2_accept_timeout: waited %0d cycles, limit 300", waits);
                break;
            end
        end
        @(posedge clk); #1;
        req2_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb1.size() != 0 || sb2.size() != 0) && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d responses still pending, expected 0", sb1.size() + sb2.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    int w1, w2, wr1, wr2;
    logic [15:0] cnt0;

    initial begin
        for (int i = 0; i < 32; i++) begin sram[i] = 0; mem_m[i] = 0; end
        rst = 1;
        req1_valid = 1; req1_we = 1; req1_addr = 5'd3; req1_wdata = $urandom;
        req2_valid = 1; req2_we = 0; req2_addr = 5'd3; req2_wdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready1", req1_ready, 0);
            check("rst_ready2", req2_ready, 0);
        end
        check("rst_CEB1", CEB1, 0); check("rst_WEB1", WEB1, 1); check("rst_OEB1", OEB1, 1);
        check("rst_CEB2", CEB2, 0); check("rst_WEB2", WEB2, 1); check("rst_OEB2", OEB2, 1);
        check("rst_CSB2", CSB2, 1); check("rst_A1", A1, 0); check("rst_I1", I1, 0);
        check("rst_A2", A2, 0); check("rst_I2", I2, 0);
        check("rst_rsp_valid", {rsp1_valid, rsp2_valid}, 0);
        check("rst_rdata", {rsp1_rdata, rsp2_rdata}, 0);
        check("rst_conflict_cnt", conflict_cnt, 0);
        check("rst_ceb_edges", ceb1_rises + ceb2_rises, 0);
        @(posedge clk); #1;
        rst = 0; req1_valid = 0; req2_valid = 0;
        @(posedge clk); #1;

        // Write then read back on port 1.
        web_low = 0; web_en = 1;
        p1_req(1, 5'd5, 32'hDEADBEEF, w1);
        p1_req(0, 5'd5, 32'h0, w1);
        drain();
        web_en = 0;
        check("web1_low_cycles", web_low, 2);

        // Port-2 read of the address port 1 is writing.
        cnt0 = conflict_cnt;
        fork
            p1_req(1, 5'd7, 32'h1, w1);
            begin @(posedge clk); #1; p2_req(0, 5'd7, 32'h0, w2); end
        join
        drain();
        check("conf_blocked_cycles", w2, 2);
        check("conf_cnt_delta", conflict_cnt - cnt0, 2);
        check("conf_strobe_order", ceb2_last > ceb1_last, 1);

        // Read/read on the same address is not a collision.
        cnt0 = conflict_cnt;
        fork
            p1_req(0, 5'd9, 32'h0, w1);
            p2_req(0, 5'd9, 32'h0, w2);
        join
        drain();
        check("rr_wait1", w1, 0);
        check("rr_wait2", w2, 0);
        check("rr_same_strobe", ceb1_last == ceb2_last, 1);
        check("rr_cnt_same", conflict_cnt, cnt0);

        // Streaming: port-2 fills memory, port-1 reads it all back.
        csb_low = 0; csb_en = 1;
        for (int i = 0; i < 32; i++) p2_req(1, 5'(i), 32'(i * 3), w2);
        drain();
        csb_en = 0;
        check("stream_csb2_low_p2", csb_low, 96);
        csb_low = 0; csb_en = 1; stream_en = 1; stream_n = 0; stream_bad = 0;
        for (int i = 0; i < 32; i++) p1_req(0, 5'(i), 32'h0, w1);
        drain();
        csb_en = 0; stream_en = 0;
        check("stream_csb2_low_p1", csb_low, 0);
        check("stream_rsp_count", stream_n, 32);
        check("stream_bad_gaps", stream_bad, 0);

        // Reset while a port-1 read is strobing drops the response.
        p1_req(0, 5'd4, 32'h0, w1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        w2 = rsp1_n;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_rsp", rsp1_n, w2);
        check("midrst_cnt", conflict_cnt, 0);
        check("midrst_rdata", rsp1_rdata, 0);
        p1_req(1, 5'd11, 32'hA5A5_0011, w1);
        p1_req(0, 5'd11, 32'h0, w1);
        drain();
        check("midrst_resume", rsp1_n, w2 + 2);

        // Randomized traffic on a few shared addresses.
        fork
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                p1_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom, wr1);
            end
            for (int j = 0; j < 40; j++) begin
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                p2_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom, wr2);
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_port_ctrl.md
# dpram_port_ctrl

Dual-port initiator that drives the two ports of the 32x32 dual-port SRAM (`dpram32x32_cb`) from two independent valid/ready request channels. It produces the SRAM's active-low strobes/enables from a single system clock, registers read data, and returns a one-cycle response per access. It also blocks same-address port collisions. It sits between the accelerator datapath (weight/activation fetch and result write-back) and the SRAM macro.

## Interface
- ADDR_W, 5, SRAM address width (32 words)
- DATA_W, 32, SRAM word width
- CNT_W, 16, conflict counter width

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- reqN_valid  in  1  request on port N (N = 1, 2)
- reqN_ready  out  1  request accepted when valid & ready at rising edge
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_W  word address
- reqN_wdata  in  DATA_W  write data
- rspN_valid  out  1  one-cycle completion pulse for every accepted access
- rspN_rdata  out  DATA_W  read data; held unchanged by writes
- AN  out  ADDR_W  SRAM address
- IN  out  DATA_W  SRAM write data
- ON  in  DATA_W  SRAM read data
- CEBN  out  1  SRAM clock/strobe; the rising edge commits the access
- WEBN  out  1  active-low write enable
- OEBN  out  1  active-low output enable
- CSB2  out  1  active-low port-2 chip select
- conflict_cnt  out  CNT_W  saturating count of cycles port 2 was blocked by a collision

## Operation
- One FSM per port: IDLE -> SETUP -> STROBE -> DONE -> (SETUP if accepted, else IDLE).
- reqN_ready = state in {IDLE, DONE} and not rst. For port 2, ready is additionally gated by `conflict`.
- Accept captures addr, we, and wdata into port registers.
- SETUP: AN and IN driven. WEBN = ~we. OEBN = we; it stays low for reads. CEBN = 0.
- STROBE: CEBN = 1. All other outputs held.
- DONE: CEBN = 0 and WEBN = 1. OEBN is still low for a read. The SRAM output is stable in this cycle.
- At the edge leaving DONE: for a read, rspN_rdata <= ON; rspN_valid = 1 for exactly the following cycle.
- OEBN returns to 1 on leaving DONE, unless the next access is a read.
- CSB2 = 0 while port 2 is in SETUP, STROBE or DONE; otherwise 1.
- conflict = req2_valid and (req2_we or port-1 op is a write) and req2_addr equals either:
  - the port-1 in-flight address (state SETUP or STROBE), or
  - req1_addr while port 1 is accepting this edge.
- Port 1 always wins a collision. Port 2 waits until port 1 is in DONE or IDLE, so the two ports never strobe the same address in the same cycle.
- Read/read on the same address is not a conflict.
- conflict_cnt increments in every cycle where req2_valid = 1, port 2 is in IDLE/DONE, and conflict = 1. It saturates at 2^CNT_W-1.

## Timing
- Reset values: CEBN = 0, WEBN = 1, OEBN = 1, CSB2 = 1, AN = 0, IN = 0, rspN_valid = 0, rspN_rdata = 0, reqN_ready = 0 during rst, conflict_cnt = 0, FSMs in IDLE.
- All SRAM-side outputs are registered, with no combinational path from req to SRAM pins. Ready is combinational.
- Request accepted at edge k:
  - SETUP is the cycle after edge k.
  - The CEBN rising edge occurs just after edge k+1.
  - rspN_valid is high in the cycle after edge k+3.
- Back-to-back throughput: one access per 3 cycles per port.
- Ports are fully independent unless a conflict exists.
- Reset mid-access: at the next edge all outputs take reset values, the in-flight access is dropped, and no response is issued. SRAM contents are undefined only if rst coincides with STROBE.
- Address wrap is not applicable: addresses are 0..31, full width, with no arithmetic.

## Test plan
- Reset: hold rst 3 cycles with requests valid -> all outputs at reset values, ready = 0, no CEB1/CEB2 edges.
- Port-1 write addr 5 data 0xDEADBEEF, then port-1 read addr 5 -> WEB1 low for exactly 2 cycles; the read returns rsp1_rdata = 0xDEADBEEF with rsp1_valid 3 cycles after accept.
- Simultaneous port-1 write addr 7 = 0x1 and port-2 read addr 7:
  - port 2 blocked 2 cycles;
  - conflict_cnt = 2;
  - the port-2 strobe follows the port-1 strobe;
  - rsp2_rdata = 0x1.
- Simultaneous reads on addr 9 from both ports -> no blocking, CEB1 and CEB2 rise in the same cycle, conflict_cnt unchanged.
- Streaming: 32 port-2 writes addr i = i*3, then 32 port-1 reads -> all match, one response every 3 cycles, CSB2 low only during port-2 accesses.
- Assert rst during port-1 STROBE of a read -> no rsp1_valid; the next accepted request runs normally.
